// File: rtl/fetch_controller_pkg.sv
// Shared processor package: fetch FSM state encoding, datapath widths and
// the default halt opcode used by the fetch stage.
package fetch_controller_pkg;

  localparam int unsigned WORD_W = 16;  // instruction word width
  localparam int unsigned ADDR_W = 16;  // instruction address width
  localparam int unsigned CNT_W  = 16;  // delivered-instruction counter width

  localparam logic [3:0] DEFAULT_HALT_OPCODE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HALTED
  } fetch_state_t;

  // Major opcode lives in the top nibble of the instruction word.
  function automatic logic [3:0] opcode_of(input logic [WORD_W-1:0] w);
    return w[WORD_W-1 -: 4];
  endfunction

endpackage

// File: rtl/fetch_controller.sv
// Instruction fetch stage driving a synchronous instruction memory.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start               - (re)start fetching from RESET_PC
//   stall               - decode-stage hazard hold
//   redirect, redirect_target - taken branch/jump and its destination
//   imem_addr/imem_rdata - memory address out, data back one cycle later
//   instr_out, pc_out, instr_valid - instruction presented to decode
//   halted              - fetch stopped on a HALT_OPCODE instruction
//   instr_count         - instructions delivered since last start (saturating)
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]        HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_valid,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] issued_pc;
  logic              issue_v;   // a memory read for issued_pc is in flight
  logic              advance;   // pipeline moves this cycle
  logic              halt_cap;  // in-flight word is a halt and is captured now

  always_comb begin
    advance  = (state == ST_FETCH) && !start && !redirect && !stall;
    halt_cap = advance && issue_v && (opcode_of(imem_rdata) == HALT_OPCODE);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (start)         state_next = ST_FETCH;
    else if (halt_cap) state_next = ST_HALTED;
  end

  // Outputs decoded from state / fetch pointer
  always_comb begin
    halted    = (state == ST_HALTED);
    imem_addr = fetch_pc;
  end

  // Fetch datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      issued_pc   <= '0;
      issue_v     <= 1'b0;
      instr_out   <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      instr_count <= '0;
    end else if (start) begin
      fetch_pc    <= RESET_PC;
      issue_v     <= 1'b0;
      instr_valid <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (redirect) begin
            fetch_pc    <= redirect_target;
            issue_v     <= 1'b0;
            instr_valid <= 1'b0;
          end else if (stall) begin
            // Data returning during a stall is dropped; rewind so the same
            // address is read again once the stall releases.
            if (issue_v) begin
              fetch_pc <= issued_pc;
              issue_v  <= 1'b0;
            end
          end else begin
            instr_valid <= issue_v;
            if (issue_v) begin
              instr_out <= imem_rdata;
              pc_out    <= issued_pc;
              if (instr_count != '1) instr_count <= instr_count + 16'd1;
            end
            // On halt capture the fetch pointer freezes and nothing new issues.
            if (halt_cap) begin
              issue_v <= 1'b0;
            end else begin
              issued_pc <= fetch_pc;
              fetch_pc  <= fetch_pc + 16'd1;
              issue_v   <= 1'b1;
            end
          end
        end
        ST_HALTED: begin
          if (!stall) instr_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

  logic        clk;
  logic        rst_n;
  logic        start, stall, redirect;
  logic [15:0] redirect_target;
  logic [15:0] imem_addr, imem_rdata, instr_out, pc_out, instr_count;
  logic        instr_valid, halted;

  logic [15:0] imem_addr2, imem_rdata2, instr_out2, pc_out2, instr_count2;
  logic        instr_valid2, halted2;

  logic [15:0] mem [0:65535];

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 0;

  fetch_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .redirect(redirect), .redirect_target(redirect_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
    .halted(halted), .instr_count(instr_count)
  );

  fetch_controller #(.RESET_PC(16'hFFFE)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .redirect(redirect), .redirect_target(redirect_target),
    .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .instr_out(instr_out2), .pc_out(pc_out2), .instr_valid(instr_valid2),
    .halted(halted2), .instr_count(instr_count2)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Synchronous instruction memory, one read port per DUT
  always @(posedge clk) begin
    imem_rdata  <= mem[imem_addr];
    imem_rdata2 <= mem[imem_addr2];
  end

  // Stream-level model: tracks the next address to deliver and how many
  // bubble cycles remain before it appears.
  typedef enum {M_IDLE, M_RUN, M_HALT} mmode_t;
  mmode_t      m_mode  = M_IDLE;
  logic [15:0] m_next  = 0;
  int          m_gap   = 0;
  logic        m_valid = 0;
  logic [15:0] m_pc    = 0;
  logic [15:0] m_instr = 0;
  logic [15:0] m_count = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_next = 0; m_gap = 0; m_valid = 0;
      m_pc = 0; m_instr = 0; m_count = 0;
    end else if (start) begin
      m_mode = M_RUN; m_next = 16'h0000; m_gap = 1; m_valid = 0; m_count = 0;
    end else begin
      case (m_mode)
        M_RUN: begin
          if (redirect) begin
            m_next = redirect_target; m_gap = 1; m_valid = 0;
          end else if (stall) begin
            if (m_gap == 0) m_gap = 1;
          end else if (m_gap > 0) begin
            m_gap = m_gap - 1; m_valid = 0;
          end else begin
            m_valid = 1;
            m_pc    = m_next;
            m_instr = mem[m_next];
            if (m_count != 16'hFFFF) m_count = m_count + 1;
            m_next  = m_next + 1;
            if (m_instr[15:12] == 4'hF) m_mode = M_HALT;
          end
        end
        M_HALT: if (!stall) m_valid = 0;
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_valid",  {15'd0, instr_valid}, {15'd0, m_valid});
      chk("m_halted", {15'd0, halted}, {15'd0, (m_mode == M_HALT)});
      chk("m_count",  instr_count, m_count);
      chk("m_pc",     pc_out, m_pc);
      chk("m_instr",  instr_out, m_instr);
    end
  end

  task automatic drive(input logic s, input logic st, input logic rd, input logic [15:0] tg);
    start = s; stall = st; redirect = rd; redirect_target = tg;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 16'h0000);
  endtask

  initial begin
    rst_n = 0; start = 0; stall = 0; redirect = 0; redirect_target = 0;
    for (int unsigned i = 0; i < 65536; i++) mem[i] = {4'h1, i[11:0]};
    mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'h9ABC; mem[3] = 16'hF000;
    repeat (2) @(negedge clk);
    rst_n  = 1;
    cmp_en = 1;

    // Reset state, then IDLE ignores redirect/stall
    chk("rst_valid",  {15'd0, instr_valid}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_addr",   imem_addr, 16'h0000);
    chk("rst_count",  instr_count, 16'd0);
    drive(0, 1, 1, 16'h0055);
    chk("idle_addr",  imem_addr, 16'h0000);
    chk("idle_valid", {15'd0, instr_valid}, 16'd0);

    // Basic run to a halt instruction
    drive(1, 0, 0, 16'h0000);
    chk("st_v1", {15'd0, instr_valid}, 16'd0);
    idle(); chk("st_v2", {15'd0, instr_valid}, 16'd0);
    idle(); chk("i0_v", {15'd0, instr_valid}, 16'd1); chk("i0_pc", pc_out, 16'h0000); chk("i0_in", instr_out, 16'h1234);
    idle(); chk("i1_pc", pc_out, 16'h0001); chk("i1_in", instr_out, 16'h5678);
    idle(); chk("i2_pc", pc_out, 16'h0002); chk("i2_in", instr_out, 16'h9ABC);
    idle(); chk("i3_pc", pc_out, 16'h0003); chk("i3_in", instr_out, 16'hF000);
    chk("i3_v", {15'd0, instr_valid}, 16'd1); chk("halt", {15'd0, halted}, 16'd1); chk("cnt4", instr_count, 16'd4);
    drive(0, 1, 0, 16'h0000);
    chk("hstall_v", {15'd0, instr_valid}, 16'd1);
    drive(0, 0, 1, 16'h0040);
    chk("hrel_v", {15'd0, instr_valid}, 16'd0); chk("hrel_halt", {15'd0, halted}, 16'd1);
    chk("hfrozen_addr", imem_addr, 16'h0004); chk("hcnt", instr_count, 16'd4);

    // Stall, redirect, redirect+stall (restart from HALTED)
    mem[0] = 16'h1000; mem[1] = 16'h1001; mem[2] = 16'h1002; mem[3] = 16'h1003;
    drive(1, 0, 0, 16'h0000);
    idle(); idle(); chk("s_pc0", pc_out, 16'h0000); chk("s_halt", {15'd0, halted}, 16'd0);
    idle(); chk("s_pc1", pc_out, 16'h0001);
    drive(0, 1, 0, 16'h0000);
    chk("s_hold_pc", pc_out, 16'h0001); chk("s_hold_v", {15'd0, instr_valid}, 16'd1);
    idle(); chk("s_bubble", {15'd0, instr_valid}, 16'd0);
    idle(); chk("s_pc2", pc_out, 16'h0002); chk("s_pc2_v", {15'd0, instr_valid}, 16'd1);
    drive(0, 0, 1, 16'h0040);
    chk("r_b1", {15'd0, instr_valid}, 16'd0);
    idle(); chk("r_b2", {15'd0, instr_valid}, 16'd0);
    idle(); chk("r_pc", pc_out, 16'h0040); chk("r_in", instr_out, 16'h1040); chk("r_v", {15'd0, instr_valid}, 16'd1);
    drive(0, 1, 1, 16'h0080);
    chk("rs_b1", {15'd0, instr_valid}, 16'd0);
    idle(); chk("rs_b2", {15'd0, instr_valid}, 16'd0);
    idle(); chk("rs_pc", pc_out, 16'h0080); chk("rs_in", instr_out, 16'h1080); chk("rs_cnt", instr_count, 16'd5);
    idle(); chk("rs_pc1", pc_out, 16'h0081);

    // Asynchronous reset between clock edges
    #2 rst_n = 0;
    #1;
    chk("ar_valid", {15'd0, instr_valid}, 16'd0);
    chk("ar_pc",    pc_out, 16'h0000);
    chk("ar_instr", instr_out, 16'h0000);
    chk("ar_count", instr_count, 16'd0);
    chk("ar_addr",  imem_addr, 16'h0000);
    @(negedge clk);
    rst_n = 1;
    idle(); chk("ar_idle_v1", {15'd0, instr_valid}, 16'd0);
    idle(); chk("ar_idle_v2", {15'd0, instr_valid}, 16'd0); chk("ar_idle_addr", imem_addr, 16'h0000);

    // Restart; second instance wraps from FFFE
    drive(1, 0, 0, 16'h0000);
    idle(); idle();
    chk("w_pc0", pc_out2, 16'hFFFE); chk("w_in0", instr_out2, 16'h1FFE); chk("w_v0", {15'd0, instr_valid2}, 16'd1);
    idle(); chk("w_pc1", pc_out2, 16'hFFFF); chk("w_in1", instr_out2, 16'h1FFF);
    idle(); chk("w_pc2", pc_out2, 16'h0000); chk("w_in2", instr_out2, 16'h1000); chk("w_cnt", instr_count2, 16'd3);
    repeat (3) idle();

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, start address loaded on start.
REQ-002 SHALL have parameter HALT_OPCODE, default 4'hF, instruction[15:12] value that stops fetch.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begin fetching from RESET_PC when idle or halted.
REQ-006 SHALL have port stall  input  1  hazard hold from the decode stage.
REQ-007 SHALL have port redirect  input  1  branch/jump taken; squash in-flight fetch.
REQ-008 SHALL have port redirect_target  input  16  next fetch address on redirect.
REQ-009 SHALL have port imem_addr  output  16  address to the synchronous instruction memory.
REQ-010 SHALL have port imem_rdata  input  16  memory data, valid one cycle after address is sampled.
REQ-011 SHALL have port instr_out  output  16  instruction to decode.
REQ-012 SHALL have port pc_out  output  16  address of instr_out.
REQ-013 SHALL have port instr_valid  output  1  instr_out/pc_out are a real instruction.
REQ-014 SHALL have port halted  output  1  high in HALTED state.
REQ-015 SHALL have port instr_count  output  16  instructions delivered since last start, saturating.

Function
REQ-016 SHALL implement states IDLE, FETCH, HALTED; IDLE/HALTED -> FETCH on start; FETCH -> HALTED on capture of a HALT_OPCODE instruction.
REQ-017 SHALL, on start: fetch_pc<=RESET_PC, issue_v<=0, instr_valid<=0, instr_count<=0.
REQ-018 SHALL drive imem_addr = fetch_pc combinationally at all times.
REQ-019 SHALL, in FETCH with redirect=1 (priority over stall): fetch_pc<=redirect_target, issue_v<=0, instr_valid<=0.
REQ-020 SHALL, in FETCH with stall=1, redirect=0: hold instr_out, pc_out, instr_valid; if issue_v, fetch_pc<=issued_pc and issue_v<=0 (in-flight data discarded, re-issued after release).
REQ-021 SHALL, in FETCH with stall=0, redirect=0: instr_valid<=issue_v; if issue_v, instr_out<=imem_rdata, pc_out<=issued_pc, instr_count increments; issued_pc<=fetch_pc; fetch_pc<=fetch_pc+1; issue_v<=1.
REQ-022 SHALL give latency: first instr_valid two edges after the start edge; steady-state throughput one instruction per cycle.
REQ-023 SHALL cost exactly one bubble cycle after stall release when a fetch was in flight, and two bubble cycles after a redirect.
REQ-024 SHALL wrap fetch_pc from 16'hFFFF to 16'h0000 with no flag.
REQ-025 SHALL, on HALT capture: present it with instr_valid=1, enter HALTED, issue_v<=0; fetch_pc frozen.
REQ-026 SHALL, in HALTED: instr_valid<=0 on first edge with stall=0, held while stall=1; redirect ignored.
REQ-027 SHALL ignore redirect and stall in IDLE; instr_valid=0 in IDLE.
REQ-028 SHALL saturate instr_count at 16'hFFFF.
REQ-029 SHALL treat start in FETCH as a restart (REQ-017 applies).

Reset
REQ-030 SHALL, on rst_n=0 at any time, immediately force state=IDLE, fetch_pc=RESET_PC, issued_pc=0, issue_v=0, instr_out=0, pc_out=0, instr_valid=0, instr_count=0, halted=0.
REQ-031 SHALL resume only on start after rst_n deasserts; reset mid-fetch discards in-flight data.

Structure
REQ-032 SHALL take state enum, 16-bit word/address width constants and default HALT_OPCODE from the shared processor package.
REQ-033 SHALL be a single module with no sub-modules; memory instantiated outside by the integrator.

Verification
REQ-034 SHALL test: reset, start, memory {0x1234,0x5678,0x9ABC,0xF000} -> valid instr 0x1234@0,0x5678@1,0x9ABC@2,0xF000@3 on consecutive cycles, then halted=1, instr_count=4.
REQ-035 SHALL test: stall one cycle while pc_out=1 -> pc_out=1 held two cycles, one bubble, then pc_out=2, no skipped/duplicated address.
REQ-036 SHALL test: redirect to 0x0040 while pc_out=2 -> two invalid cycles, next valid pc_out=0x0040.
REQ-037 SHALL test: redirect and stall same cycle -> redirect wins, next valid pc_out=redirect_target.
REQ-038 SHALL test: RESET_PC=16'hFFFE, non-halt memory -> pc_out sequence FFFE,FFFF,0000.
REQ-039 SHALL test: rst_n low mid-FETCH between edges -> outputs zero immediately, IDLE, no instr_valid until new start.
